// File: rtl/toggle_meter_pkg.sv
// ============================================================================
// Module      : toggle_meter_pkg
// Description : Shared types and constants for the toggle period meter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package toggle_meter_pkg;

    localparam int c_default_width       = 8;
    localparam int c_default_sync_stages = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_SAT  = 2'd2
    } meter_state_e;

    // Largest count representable in a counter of the given width.
    function automatic int unsigned sat_count(input int unsigned width);
        return (32'd1 << width) - 32'd1;
    endfunction

endpackage : toggle_meter_pkg

`default_nettype wire

// File: rtl/toggle_period_meter_edge_sync.sv
// ============================================================================
// Module      : edge_sync
// Description : Synchronizer chain for an asynchronous toggle input plus
//               single-cycle rising-edge detector.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic tin,
    output logic ts,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   prev_q;
    logic                   prev_d;

    generate
        if (SYNC_STAGES > 1) begin : g_chain
            always_comb sync_d = {sync_q[SYNC_STAGES-2:0], tin};
        end else begin : g_single
            always_comb sync_d = tin;
        end
    endgenerate

    always_comb begin
        prev_d = sync_q[SYNC_STAGES-1];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign ts   = sync_q[SYNC_STAGES-1];
    assign rise = ts & ~prev_q;

endmodule : edge_sync

`default_nettype wire

// File: rtl/toggle_period_meter.sv
// ============================================================================
// Module      : toggle_period_meter
// Description : Measures period and high time of a toggled input in clock
//               cycles, with valid strobe, overflow flag and ratio lock.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module toggle_period_meter
    import toggle_meter_pkg::*;
#(
    parameter int WIDTH       = c_default_width,
    parameter int SYNC_STAGES = c_default_sync_stages
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             tin,
    input  logic             clear,
    output logic [WIDTH-1:0] period,
    output logic [WIDTH-1:0] high_time,
    output logic             valid,
    output logic             overflow,
    output logic             locked
);

    localparam logic [WIDTH-1:0] c_sat = WIDTH'(sat_count(WIDTH));
    localparam logic [WIDTH-1:0] c_one = {{(WIDTH-1){1'b0}}, 1'b1};

    logic ts;
    logic rise;

    meter_state_e     state_q,     state_d;
    logic [WIDTH-1:0] cnt_q,       cnt_d;
    logic [WIDTH-1:0] hcnt_q,      hcnt_d;
    logic [WIDTH-1:0] period_q,    period_d;
    logic [WIDTH-1:0] high_time_q, high_time_d;
    logic             valid_q,     valid_d;
    logic             overflow_q,  overflow_d;
    logic             locked_q,    locked_d;
    logic [WIDTH-1:0] hcnt_acc;

    edge_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_edge_sync (
        .clock (clock),
        .reset (reset),
        .tin   (tin),
        .ts    (ts),
        .rise  (rise)
    );

    // High-time accumulator never wraps, even while the period is saturated.
    always_comb begin
        hcnt_acc = hcnt_q;
        if (ts && (hcnt_q != c_sat)) begin
            hcnt_acc = hcnt_q + c_one;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        hcnt_d      = hcnt_q;
        period_d    = period_q;
        high_time_d = high_time_q;
        valid_d     = 1'b0;
        overflow_d  = overflow_q;
        locked_d    = locked_q;

        if (clear) begin
            state_d     = ST_IDLE;
            cnt_d       = '0;
            hcnt_d      = '0;
            period_d    = '0;
            high_time_d = '0;
            overflow_d  = 1'b0;
            locked_d    = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (rise) begin
                        state_d = ST_RUN;
                        cnt_d   = c_one;
                        hcnt_d  = c_one;
                    end
                end
                ST_RUN: begin
                    if (rise) begin
                        period_d    = cnt_q;
                        high_time_d = hcnt_q;
                        overflow_d  = 1'b0;
                        valid_d     = 1'b1;
                        locked_d    = (cnt_q == period_q) && !overflow_q;
                        cnt_d       = c_one;
                        hcnt_d      = c_one;
                    end else if (cnt_q == c_sat) begin
                        state_d = ST_SAT;
                        hcnt_d  = hcnt_acc;
                    end else begin
                        cnt_d  = cnt_q + c_one;
                        hcnt_d = hcnt_acc;
                    end
                end
                ST_SAT: begin
                    if (rise) begin
                        period_d    = c_sat;
                        high_time_d = hcnt_q;
                        overflow_d  = 1'b1;
                        valid_d     = 1'b1;
                        locked_d    = 1'b0;
                        cnt_d       = c_one;
                        hcnt_d      = c_one;
                        state_d     = ST_RUN;
                    end else begin
                        hcnt_d = hcnt_acc;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            hcnt_q      <= '0;
            period_q    <= '0;
            high_time_q <= '0;
            valid_q     <= 1'b0;
            overflow_q  <= 1'b0;
            locked_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hcnt_q      <= hcnt_d;
            period_q    <= period_d;
            high_time_q <= high_time_d;
            valid_q     <= valid_d;
            overflow_q  <= overflow_d;
            locked_q    <= locked_d;
        end
    end

    assign period    = period_q;
    assign high_time = high_time_q;
    assign valid     = valid_q;
    assign overflow  = overflow_q;
    assign locked    = locked_q;

endmodule : toggle_period_meter

`default_nettype wire

// File: tb/tb_toggle_period_meter.sv
// ============================================================================
// Module      : tb_toggle_period_meter
// Description : Directed self-checking bench for toggle_period_meter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_toggle_period_meter;

    localparam int WIDTH       = 8;
    localparam int SYNC_STAGES = 2;

    logic             clock = 1'b0;
    logic             reset;
    logic             tin;
    logic             clear;
    logic [WIDTH-1:0] period;
    logic [WIDTH-1:0] high_time;
    logic             valid;
    logic             overflow;
    logic             locked;

    toggle_period_meter #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .tin       (tin),
        .clear     (clear),
        .period    (period),
        .high_time (high_time),
        .valid     (valid),
        .overflow  (overflow),
        .locked    (locked)
    );

    always #5 clock = ~clock;

    typedef struct {
        int per;
        int hi;
        int ovf;
        int lck;
        int cyc;
    } rep_t;

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    rep_t reps[$];
    int   rise_set[$];
    rep_t mon_r;

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (valid) begin
            mon_r.per = int'(period);
            mon_r.hi  = int'(high_time);
            mon_r.ovf = int'(overflow);
            mon_r.lck = int'(locked);
            mon_r.cyc = cyc;
            reps.push_back(mon_r);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            if (v && !tin) rise_set.push_back(cyc);
            tin = v;
        end
    endtask

    task automatic pulses(input int h, input int l, input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b1, h);
            drive(1'b0, l);
        end
    endtask

    task automatic do_clear();
        @(negedge clock);
        clear = 1'b1;
        @(negedge clock);
        clear = 1'b0;
    endtask

    task automatic reset_log();
        reps.delete();
        rise_set.delete();
    endtask

    task automatic check_rep(input string tag, input int idx, input int per,
                             input int hi, input int ovf, input int lck);
        if (idx < reps.size()) begin
            check($sformatf("%s[%0d].period", tag, idx), reps[idx].per, per);
            check($sformatf("%s[%0d].high", tag, idx), reps[idx].hi, hi);
            check($sformatf("%s[%0d].ovf", tag, idx), reps[idx].ovf, ovf);
            check($sformatf("%s[%0d].locked", tag, idx), reps[idx].lck, lck);
        end else begin
            check($sformatf("%s[%0d].present", tag, idx), reps.size(), idx + 1);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, ".period"}, period, 0);
        check({tag, ".high"}, high_time, 0);
        check({tag, ".valid"}, valid, 0);
        check({tag, ".ovf"}, overflow, 0);
        check({tag, ".locked"}, locked, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        tin   = 1'b0;
        clear = 1'b0;
        repeat (3) @(negedge clock);
        check_outputs_zero("reset");
        reset = 1'b0;
        drive(1'b0, 3);

        // Period 2: toggling every clock
        reset_log();
        pulses(1, 1, 6);
        drive(1'b0, 8);
        check("p2.count", reps.size(), 5);
        for (int k = 0; k < 5; k++) begin
            check_rep("p2", k, 2, 1, 0, (k > 0) ? 1 : 0);
            if (k > 0 && k < reps.size())
                check($sformatf("p2[%0d].spacing", k), reps[k].cyc - reps[k-1].cyc, 2);
        end
        do_clear();

        // Divide-by-8, 4 high / 4 low
        reset_log();
        pulses(4, 4, 3);
        drive(1'b0, 8);
        check("d8.count", reps.size(), 2);
        check_rep("d8", 0, 8, 4, 0, 0);
        check_rep("d8", 1, 8, 4, 0, 1);
        if (reps.size() >= 2 && rise_set.size() >= 2) begin
            check("d8.spacing", reps[1].cyc - reps[0].cyc, 8);
            check("d8.latency", reps[0].cyc - rise_set[1], SYNC_STAGES + 1);
        end
        do_clear();

        // Overflow: 304-cycle period, then 10-cycle period
        reset_log();
        pulses(4, 300, 1);
        drive(1'b1, 4);
        drive(1'b0, 2);
        check("ovf.held", overflow, 1);
        check("ovf.valid_low", valid, 0);
        drive(1'b0, 4);
        drive(1'b1, 1);
        drive(1'b0, 6);
        check("ovf.count", reps.size(), 2);
        check_rep("ovf", 0, 255, 4, 1, 0);
        check_rep("ovf", 1, 10, 4, 0, 0);
        do_clear();

        // Exactly 255 cycles reports normally and can lock
        reset_log();
        pulses(5, 250, 2);
        drive(1'b1, 1);
        drive(1'b0, 6);
        check("p255.count", reps.size(), 2);
        check_rep("p255", 0, 255, 5, 0, 0);
        check_rep("p255", 1, 255, 5, 0, 1);
        do_clear();

        // High time saturates independently
        reset_log();
        pulses(300, 5, 1);
        drive(1'b1, 1);
        drive(1'b0, 6);
        check("hsat.count", reps.size(), 1);
        check_rep("hsat", 0, 255, 255, 1, 0);
        do_clear();

        // Clear coincident with a rise in RUN discards that edge
        reset_log();
        drive(1'b1, 2);
        drive(1'b0, 6);
        drive(1'b1, SYNC_STAGES);
        @(negedge clock);
        clear = 1'b1;
        @(negedge clock);
        clear = 1'b0;
        drive(1'b0, 3);
        check("clr.no_valid", reps.size(), 0);
        pulses(3, 3, 1);
        check("clr.first_edge_silent", reps.size(), 0);
        drive(1'b1, 1);
        drive(1'b0, 6);
        check("clr.count", reps.size(), 1);
        check_rep("clr", 0, 6, 3, 0, 0);
        do_clear();

        // Reset mid-period
        reset_log();
        pulses(2, 4, 2);
        drive(1'b1, 2);
        drive(1'b0, 1);
        check("rst.pre_count", reps.size(), 1);
        @(negedge clock);
        reset = 1'b1;
        tin   = 1'b0;
        @(negedge clock);
        check_outputs_zero("rst_mid");
        reset = 1'b0;
        reset_log();
        drive(1'b0, 3);
        pulses(2, 4, 3);
        drive(1'b1, 1);
        drive(1'b0, 6);
        check("rst.count", reps.size(), 3);
        check_rep("rst", 0, 6, 2, 0, 0);
        check_rep("rst", 1, 6, 2, 0, 1);
        check_rep("rst", 2, 6, 2, 0, 1);
        do_clear();

        // Ratio change 4,4,6,6
        reset_log();
        pulses(2, 2, 2);
        pulses(3, 3, 2);
        drive(1'b1, 1);
        drive(1'b0, 8);
        check("ratio.count", reps.size(), 4);
        check_rep("ratio", 0, 4, 2, 0, 0);
        check_rep("ratio", 1, 4, 2, 0, 1);
        check_rep("ratio", 2, 6, 3, 0, 0);
        check_rep("ratio", 3, 6, 3, 0, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_toggle_period_meter

`default_nettype wire

// File: doc/toggle_period_meter.md
Name: toggle_period_meter

Overview:
Receive-side companion to the toggle flip-flop divider. Samples a divided or toggled signal (e.g. divider Q) in the main clock domain, detects rising edges and measures period and high time in clock cycles. Reports one result per input period with a single-cycle valid strobe, and flags lock once the ratio is stable. Sits downstream of the divider chain as a self-check and ratio monitor.

Parameters:
WIDTH, 8, width of period/high-time counters and outputs
SYNC_STAGES, 2, number of synchronizer flops on tin (minimum 2)

Ports:
clock  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
tin  input  1  toggle input under measurement (asynchronous to clock)
clear  input  1  synchronous soft clear of measurement state; synchronizer chain unaffected
period  output  WIDTH  clock cycles between last two rising edges of tin
high_time  output  WIDTH  clock cycles tin was high within that period
valid  output  1  one-cycle strobe: period/high_time/overflow updated
overflow  output  1  reported period exceeded 2^WIDTH-1 (qualified by valid, held until next valid)
locked  output  1  last two consecutive reported periods equal and both non-overflow

Behaviour:
- Reset: period=0, high_time=0, valid=0, overflow=0, locked=0, sync chain=0, edge prev=0, state=IDLE.
- Sync: tin passes through SYNC_STAGES flops -> ts; prev <= ts every cycle; rise = ts & ~prev (combinational, cycle-exact).
- Latency: tin high at clock edge k -> rise in cycle k+SYNC_STAGES -> valid high in cycle k+SYNC_STAGES+1 (registered).
- States: IDLE, RUN, SAT.
- IDLE: ignore ts level; on rise -> RUN, cnt<=1, hcnt<=1 (ts is high). No valid from first edge.
- RUN: each cycle cnt<=cnt+1, hcnt<=hcnt+ts. On rise: period<=cnt, high_time<=hcnt, overflow<=0, valid<=1; cnt<=1, hcnt<=1. If cnt reaches 2^WIDTH-1 without rise -> SAT.
- SAT: counters hold at saturation (hcnt saturates independently, never wraps). On rise: period<=all ones, high_time<=saturated hcnt, overflow<=1, valid<=1, locked<=0, restart counters, -> RUN.
- Period exactly 2^WIDTH-1: reported normally, overflow=0 (SAT entered but rise on that cycle wins; treat as RUN rise).
- locked: on each non-overflow valid, locked <= (new period == previous reported period) and previous was non-overflow; any overflow report clears it.
- clear: same effect as reset on all state except sync chain and prev; clear and rise in same cycle -> clear wins, edge discarded, state IDLE.
- reset mid-measurement: in-flight count discarded, no valid emitted.
- Constant tin (0 or 1): no valid ever; counters saturate silently in SAT.
- Minimum measurable period 2 (tin toggling every cycle); tin faster than clock/2 aliases, not detected.

Decomposition:
- Package toggle_meter_pkg: state enum (IDLE, RUN, SAT), default WIDTH/SYNC_STAGES constants, saturation constant helper.
- Sub-module edge_sync: SYNC_STAGES synchronizer + prev register, outputs ts and rise. Measurement FSM and counters stay in top.

Test Plan:
- tin = toggle flip-flop output toggling every clock (period 2) -> after first edge, valid every 2 cycles, period=2, high_time=1, locked=1 from second report.
- tin divide-by-8 (4 high, 4 low) -> period=8, high_time=4, valid spacing 8, first valid SYNC_STAGES+1 cycles after second tin rise edge, locked=1 on second report.
- tin held low 300 cycles after an edge (WIDTH=8) then rises -> valid with period=255, overflow=1, locked=0; next 10-cycle period -> period=10, overflow=0.
- clear asserted in the same cycle as a rise while in RUN -> no valid, state IDLE; next rise starts measurement, first valid only on the rise after that.
- reset pulsed mid-period -> all outputs 0 next cycle, no spurious valid; period 6/duty 2 afterwards reports period=6, high_time=2.
- Ratio change 4 -> 6 -> 6 -> locked sequence 1 (after 4,4), 0, 1.
